// File: rtl/calc_sequencer_pkg.sv
// Shared calculator types: operation encoding and sign-magnitude word helpers.
package calc_sequencer_pkg;

    typedef logic [15:0] sm_word_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ADD   = 2'd1,
        SUB   = 2'd2,
        CLEAR = 2'd3
    } calc_op_t;

    localparam sm_word_t SM_NEG_ZERO = 16'h8000;

    // Negative zero is folded to positive zero; every other encoding is kept.
    function automatic sm_word_t sm_normalise(input sm_word_t w);
        return (w == SM_NEG_ZERO) ? '0 : w;
    endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Calculator entry sequencer: keeps a sign-magnitude accumulator and drives the
// add unit's four-phase start/finish handshake, with a watchdog on both waits.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        entry_valid,
    output logic        entry_ready,
    input  logic [1:0]  entry_op,
    input  logic [15:0] entry_value,
    output logic        add_start,
    output logic [15:0] add_in1,
    output logic [15:0] add_in2,
    output logic        add_sub,
    input  logic        add_finish,
    input  logic [15:0] add_out,
    output logic [15:0] acc,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FIN = 2'd1,
        WAIT_REL = 2'd2,
        ERROR    = 2'd3
    } seq_state_t;

    seq_state_t       state_q, state_d;
    logic             start_q, start_d;
    sm_word_t         in1_q, in1_d;
    sm_word_t         in2_q, in2_d;
    logic             sub_q, sub_d;
    sm_word_t         acc_q, acc_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign entry_ready  = (state_q == IDLE) && !add_finish;
    assign busy         = (state_q != IDLE);
    assign add_start    = start_q;
    assign add_in1      = in1_q;
    assign add_in2      = in2_q;
    assign add_sub      = sub_q;
    assign acc          = acc_q;
    assign result_valid = rv_q;
    assign err          = err_q;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        rv_d    = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (entry_valid && entry_ready) begin
                    case (calc_op_t'(entry_op))
                        LOAD: begin
                            acc_d = sm_normalise(entry_value);
                            rv_d  = 1'b1;
                        end
                        CLEAR: begin
                            acc_d = '0;
                            rv_d  = 1'b1;
                        end
                        ADD, SUB: begin
                            in1_d   = acc_q;
                            in2_d   = entry_value;
                            sub_d   = (calc_op_t'(entry_op) == SUB);
                            start_d = 1'b1;
                            cnt_d   = '0;
                            state_d = WAIT_FIN;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_FIN: begin
                // The awaited edge is tested first so it wins over a coincident timeout.
                if (add_finish) begin
                    acc_d   = sm_normalise(add_out);
                    rv_d    = 1'b1;
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!add_finish) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERROR: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            sub_q   <= 1'b0;
            acc_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural add-unit responder.
module tb_calc_sequencer;
    import calc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        entry_valid = 1'b0;
    logic        entry_ready;
    logic [1:0]  entry_op = 2'd0;
    logic [15:0] entry_value = 16'h0000;
    logic        add_start;
    logic [15:0] add_in1, add_in2;
    logic        add_sub;
    logic        add_finish = 1'b0;
    logic [15:0] add_out = 16'h0000;
    logic [15:0] acc;
    logic        result_valid;
    logic        busy;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] sb[$];
    logic [15:0] model_acc = 16'h0000;

    bit resp_manual = 1'b0;
    bit resp_hang   = 1'b0;
    int resp_extra  = 0;
    int fin_obs     = 0;
    int rel_obs     = 0;

    calc_sequencer #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .RST          (RST),
        .entry_valid  (entry_valid),
        .entry_ready  (entry_ready),
        .entry_op     (entry_op),
        .entry_value  (entry_value),
        .add_start    (add_start),
        .add_in1      (add_in1),
        .add_in2      (add_in2),
        .add_sub      (add_sub),
        .add_finish   (add_finish),
        .add_out      (add_out),
        .acc          (acc),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sm2int(input logic [15:0] x);
        return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    endfunction

    // Sign-magnitude add with 15-bit magnitude wrap; a zero sum keeps a's sign.
    function automatic logic [15:0] sm_calc(input logic [15:0] a, input logic [15:0] b, input bit sub);
        int s = sm2int(a) + (sub ? -sm2int(b) : sm2int(b));
        int m = (s < 0) ? -s : s;
        logic [14:0] mm = m[14:0];
        if (mm == 15'd0) return {a[15], 15'd0};
        return {(s < 0), mm};
    endfunction

    function automatic logic [15:0] norm(input logic [15:0] w);
        return (w == 16'h8000) ? 16'h0000 : w;
    endfunction

    // Finish is seen by the sequencer at acceptance +5 and released so that it reads 0 at +8.
    always begin
        @(posedge clk);
        #1;
        if (!resp_manual) begin
            if (!add_finish) begin
                if (add_start && !resp_hang) fin_obs++;
                else fin_obs = 0;
                if (fin_obs == 5) begin
                    add_out    = sm_calc(add_in1, add_in2, add_sub);
                    add_finish = 1'b1;
                    fin_obs    = 0;
                    rel_obs    = 0;
                end else begin
                    add_out = 16'($urandom);
                end
            end else if (!add_start) begin
                rel_obs++;
                if (rel_obs >= 3 + resp_extra) add_finish = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) check_eq("unexpected_result_valid", 32'd1, 32'd0);
            else check_eq("acc", acc, sb.pop_front());
        end
    end

    task automatic send(input logic [1:0] op, input logic [15:0] val, input bit push, input bit hold);
        int n = 0;
        logic [15:0] e;
        @(negedge clk);
        entry_valid = 1'b1;
        entry_op    = op;
        entry_value = val;
        while (!entry_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!entry_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            entry_valid = 1'b0;
        end else begin
            if (push) begin
                case (op)
                    2'd0: e = norm(val);
                    2'd3: e = 16'h0000;
                    default: e = norm(sm_calc(model_acc, val, op == 2'd2));
                endcase
                model_acc = e;
                sb.push_back(e);
            end
            @(negedge clk);
            if (!hold) entry_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        model_acc = 16'h0000;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input logic exp_ready);
        check_eq("rst_add_start", add_start, 0);
        check_eq("rst_add_in1", add_in1, 0);
        check_eq("rst_add_in2", add_in2, 0);
        check_eq("rst_add_sub", add_sub, 0);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_result_valid", result_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_entry_ready", entry_ready, exp_ready);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        RST = 1'b0;
        check_reset_outputs(1'b1);

        // Basic add with cycle-exact handshake timing and held entry_valid.
        send(2'd0, 16'h0005, 1'b1, 1'b0);
        check_eq("ready_after_load", entry_ready, 1);
        send(2'd1, 16'h0003, 1'b1, 1'b1);
        check_eq("start_at_accept", add_start, 1);
        entry_value = 16'h7fff;
        entry_op    = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("rv_at_%0d", k), result_valid, (k == 5));
            check_eq($sformatf("ready_at_%0d", k), entry_ready, (k >= 8));
            check_eq($sformatf("start_at_%0d", k), add_start, (k < 5));
            if (add_start) begin
                check_eq("hold_in1", add_in1, 16'h0005);
                check_eq("hold_in2", add_in2, 16'h0003);
                check_eq("hold_sub", add_sub, 0);
            end
            if (k == 7) entry_valid = 1'b0;
        end

        // Sign change, negative-zero handling, clear and magnitude wrap.
        send(2'd0, 16'h0002, 1'b1, 1'b0);
        send(2'd2, 16'h0007, 1'b1, 1'b0);
        send(2'd1, 16'h8000, 1'b1, 1'b0);
        send(2'd0, 16'h8000, 1'b1, 1'b0);
        send(2'd0, 16'h8004, 1'b1, 1'b0);
        send(2'd1, 16'h0004, 1'b1, 1'b0);
        send(2'd3, 16'h1234, 1'b1, 1'b0);
        check_eq("ready_after_clear", entry_ready, 1);
        send(2'd0, 16'h7fff, 1'b1, 1'b0);
        send(2'd1, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            send(2'($urandom_range(0, 3)), 16'($urandom), 1'b1, 1'b0);

        // Stale finish: responder keeps finish high three extra cycles.
        resp_extra = 3;
        send(2'd1, 16'h0001, 1'b1, 1'b0);
        n = 0;
        while (add_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_fell", add_start, 0);
        for (int j = 0; j < 6; j++) begin
            check_eq("stale_ready", entry_ready, 0);
            check_eq("stale_busy", busy, 1);
            @(negedge clk);
        end
        check_eq("stale_ready_back", entry_ready, 1);
        resp_extra = 0;
        repeat (2) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);

        // Watchdog: responder never finishes.
        resp_hang = 1'b1;
        send(2'd1, 16'h0010, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            check_eq($sformatf("err_at_%0d", k), err, 0);
            check_eq("wd_busy", busy, 1);
        end
        @(negedge clk);
        check_eq("err_at_8", err, 1);
        check_eq("wd_start", add_start, 0);
        check_eq("wd_acc", acc, model_acc);
        entry_valid = 1'b1;
        entry_op    = 2'd0;
        entry_value = 16'h0042;
        repeat (4) begin
            @(negedge clk);
            check_eq("err_ready", entry_ready, 0);
            check_eq("err_sticky", err, 1);
        end
        entry_valid = 1'b0;
        resp_hang = 1'b0;
        do_reset();
        check_eq("err_cleared", err, 0);
        check_eq("ready_after_rst", entry_ready, 1);

        // Reset mid-operation with a stale finish afterwards.
        resp_manual = 1'b1;
        add_finish  = 1'b0;
        send(2'd1, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        RST        = 1'b1;
        add_finish = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b0);
        RST = 1'b0;
        model_acc = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_ready", entry_ready, 0);
            check_eq("post_rst_start", add_start, 0);
        end
        add_finish = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready_back", entry_ready, 1);
        resp_manual = 1'b0;

        // Accumulator resumes normally after reset.
        send(2'd1, 16'h8003, 1'b1, 1'b0);
        n = 0;
        while (!entry_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("final_idle", entry_ready, 1);
        check_eq("final_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
